// File: rtl/swi_debounce_if.sv
// Switch-conditioner signal bundle: raw switch levels in, debounced levels and event pulses out.
// glitch_cnt exists only when SWI_DEBOUNCE_GLITCH_EN is defined.
interface swi_debounce_if #(
  parameter int NBITS = 8
);
  logic [NBITS-1:0] swi_raw;
  logic [NBITS-1:0] swi_clean;
  logic [NBITS-1:0] swi_rise;
  logic [NBITS-1:0] swi_fall;
  logic             swi_changed;
`ifdef SWI_DEBOUNCE_GLITCH_EN
  logic [7:0]       glitch_cnt;
`endif

  // Switch side drives raw levels and consumes the conditioned view.
  modport master (
    output swi_raw,
    input  swi_clean, swi_rise, swi_fall, swi_changed
`ifdef SWI_DEBOUNCE_GLITCH_EN
    , input glitch_cnt
`endif
  );

  modport slave (
    input  swi_raw,
    output swi_clean, swi_rise, swi_fall, swi_changed
`ifdef SWI_DEBOUNCE_GLITCH_EN
    , output glitch_cnt
`endif
  );
endinterface

// File: rtl/swi_debounce.sv
// Per-bit two-flop synchroniser plus stability-counter debouncer with one-cycle rise/fall pulses.
// Define SWI_DEBOUNCE_GLITCH_EN to add the saturating rejected-bounce counter (glitch_cnt).
module swi_debounce #(
  parameter int NBITS           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic          clk_2,
  input  logic          reset,
  swi_debounce_if.slave swi
);
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0]            s1_d, s1_q;
  logic [NBITS-1:0]            s2_d, s2_q;
  logic [NBITS-1:0]            clean_d, clean_q;
  logic [NBITS-1:0]            rise_d, rise_q;
  logic [NBITS-1:0]            fall_d, fall_q;
  logic [NBITS-1:0][CNT_W-1:0] cnt_d, cnt_q;
`ifdef SWI_DEBOUNCE_GLITCH_EN
  logic                        glitch_any;
  logic [7:0]                  glitch_d, glitch_q;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    s1_d    = swi.swi_raw;
    s2_d    = s1_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
`ifdef SWI_DEBOUNCE_GLITCH_EN
    glitch_any = 1'b0;
`endif
    for (int i = 0; i < NBITS; i++) begin
      if (s2_q[i] == clean_q[i]) begin
        // Back at the clean level: any partial count was a bounce.
        cnt_d[i] = '0;
`ifdef SWI_DEBOUNCE_GLITCH_EN
        if (cnt_q[i] != '0) glitch_any = 1'b1;
`endif
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i] = s2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
`ifdef SWI_DEBOUNCE_GLITCH_EN
    glitch_d = glitch_q;
    if (glitch_any && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
`endif
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
`ifdef SWI_DEBOUNCE_GLITCH_EN
      glitch_q <= '0;
`endif
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef SWI_DEBOUNCE_GLITCH_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign swi.swi_clean   = clean_q;
  assign swi.swi_rise    = rise_q;
  assign swi.swi_fall    = fall_q;
  assign swi.swi_changed = |(rise_q | fall_q);
`ifdef SWI_DEBOUNCE_GLITCH_EN
  assign swi.glitch_cnt  = glitch_q;
`endif
endmodule

// File: tb/tb_swi_debounce.sv
// Scoreboard bench for swi_debounce: stimulus pushes expected switch events, a monitor pops
// and compares them whenever swi_changed is seen.
`timescale 1ns/1ps
module tb_swi_debounce;
  localparam int NBITS = 8;
  localparam int DB    = 4;
  localparam int LAT   = 2 + DB;

  typedef struct {
    int         edge_no;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
  } event_t;

  logic   clk_2 = 1'b0;
  logic   reset = 1'b1;
  int     cyc     = 0;
  int     vec_cnt = 0;
  int     err_cnt = 0;
  event_t sb_q[$];

  swi_debounce_if #(.NBITS(NBITS)) swi ();

  swi_debounce #(.NBITS(NBITS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .swi   (swi)
  );

  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  // Event lands LAT edges after the edge that first samples the new level.
  task automatic push_event(input logic [7:0] c, input logic [7:0] r, input logic [7:0] f);
    event_t e;
    e.edge_no = cyc + LAT;
    e.clean   = c;
    e.rise    = r;
    e.fall    = f;
    sb_q.push_back(e);
  endtask

  // Monitor: drop overdue expectations as failures, then match any presented event.
  always @(negedge clk_2) begin
    while (sb_q.size() > 0 && sb_q[0].edge_no < cyc) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL missing_event: no event by edge %0d, expected clean=%h rise=%h fall=%h at edge %0d",
               cyc, sb_q[0].clean, sb_q[0].rise, sb_q[0].fall, sb_q[0].edge_no);
      void'(sb_q.pop_front());
    end
    if (swi.swi_changed) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_event: changed=1 rise=%h fall=%h at edge %0d, expected no event",
                 swi.swi_rise, swi.swi_fall, cyc);
      end else begin
        event_t e;
        e = sb_q.pop_front();
        check("event_edge", cyc, e.edge_no);
        check("event_clean", {24'd0, swi.swi_clean}, {24'd0, e.clean});
        check("event_rise", {24'd0, swi.swi_rise}, {24'd0, e.rise});
        check("event_fall", {24'd0, swi.swi_fall}, {24'd0, e.fall});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    swi.swi_raw = 8'h00;
    reset       = 1'b1;

    // Reset held 3 cycles, then idle with switches low.
    tick(3);
    check("reset_clean", {24'd0, swi.swi_clean}, 32'h0);
    check("reset_rise", {24'd0, swi.swi_rise}, 32'h0);
    check("reset_fall", {24'd0, swi.swi_fall}, 32'h0);
    check("reset_changed", {31'd0, swi.swi_changed}, 32'h0);
`ifdef SWI_DEBOUNCE_GLITCH_EN
    check("reset_glitch", {24'd0, swi.glitch_cnt}, 32'h0);
`endif
    reset = 1'b0;
    tick(12);
    check("idle_clean", {24'd0, swi.swi_clean}, 32'h0);

    // Single bit rise, then its fall.
    swi.swi_raw = 8'h01;
    push_event(8'h01, 8'h01, 8'h00);
    tick(10);
    check("bit0_clean", {24'd0, swi.swi_clean}, 32'h01);
    swi.swi_raw = 8'h00;
    push_event(8'h00, 8'h00, 8'h01);
    tick(10);

    // One-cycle bounce on bit 0: rejected.
    swi.swi_raw = 8'h01;
    tick(1);
    swi.swi_raw = 8'h00;
    tick(10);
    check("bounce_clean", {24'd0, swi.swi_clean}, 32'h00);
`ifdef SWI_DEBOUNCE_GLITCH_EN
    check("bounce_glitch", {24'd0, swi.glitch_cnt}, 32'd1);
`endif

    // All bits rise together, then the upper nibble falls together.
    swi.swi_raw = 8'hFF;
    push_event(8'hFF, 8'hFF, 8'h00);
    tick(10);
    swi.swi_raw = 8'h0F;
    push_event(8'h0F, 8'h00, 8'hF0);
    tick(10);
    check("nibble_clean", {24'd0, swi.swi_clean}, 32'h0F);

    // Reset mid-count: pending counts discarded, power-up level reported as a rise.
    swi.swi_raw = 8'h80;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midreset_clean", {24'd0, swi.swi_clean}, 32'h00);
    reset = 1'b0;
    push_event(8'h80, 8'h80, 8'h00);
    tick(10);
    check("postreset_clean", {24'd0, swi.swi_clean}, 32'h80);

    // 300 single-cycle glitches on bit 2.
    repeat (300) begin
      swi.swi_raw = 8'h84;
      tick(1);
      swi.swi_raw = 8'h80;
      tick(1);
    end
    tick(8);
    check("glitch_train_clean", {24'd0, swi.swi_clean}, 32'h80);
`ifdef SWI_DEBOUNCE_GLITCH_EN
    check("glitch_saturate", {24'd0, swi.glitch_cnt}, 32'd255);
`endif

    // Bounce partway through a count restarts it from the last stable edge.
    swi.swi_raw = 8'h82;
    tick(3);
    swi.swi_raw = 8'h80;
    tick(1);
    swi.swi_raw = 8'h82;
    push_event(8'h82, 8'h02, 8'h00);
    tick(10);
    check("restart_clean", {24'd0, swi.swi_clean}, 32'h82);

    tick(2);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
